// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder (23LC1024-style sequential mode) backed by a small internal array.
// Optional feature: define IDLI_SQI_MEM_RDMR_EN to accept command 0x05 (read mode register).
module idli_sqi_mem_m #(
  parameter int DEPTH = 256
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_SKIP
  } state_e;

  state_e      state_q, state_d;
  logic        sck_q, sck_prev_q, cs_q;
  logic [3:0]  sio_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_rd_q, is_rd_d;
  logic        rdmr_q, rdmr_d;
  logic        half_q, half_d;
  logic [23:0] addr_q, addr_d, addr_inc;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  sio_out_q, sio_out_d;
  logic        oe_q, oe_d;
  logic        rise, fall;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_q [DEPTH];

  assign rise     = sck_q & ~sck_prev_q;
  assign fall     = ~sck_q & sck_prev_q;
  assign addr_inc = {addr_q[23:AW], addr_q[AW-1:0] + 1'b1};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    rdmr_d    = rdmr_q;
    half_d    = half_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    sio_out_d = sio_out_q;
    oe_d      = oe_q;
    mem_we    = 1'b0;
    mem_wdata = {shift_q[7:4], sio_q};
    // Chip select release overrides any edge seen in the same cycle.
    if (cs_q) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      half_d    = 1'b0;
      sio_out_d = '0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (rise) begin
          shift_d = {4'h0, sio_q};
          state_d = ST_CMD;
        end
        ST_CMD: if (rise) begin
          cnt_d  = '0;
          rdmr_d = 1'b0;
          unique case ({shift_q[3:0], sio_q})
            8'h03: begin is_rd_d = 1'b1; state_d = ST_ADDR; end
            8'h02: begin is_rd_d = 1'b0; state_d = ST_ADDR; end
`ifdef IDLI_SQI_MEM_RDMR_EN
            8'h05: begin
              rdmr_d  = 1'b1;
              shift_d = 8'h40;
              half_d  = 1'b0;
              state_d = ST_RDATA;
            end
`endif
            default: state_d = ST_SKIP;
          endcase
        end
        ST_ADDR: if (rise) begin
          addr_d = {addr_q[19:0], sio_q};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d   = '0;
            half_d  = 1'b0;
            state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
          end
        end
        ST_DUMMY: if (rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = '0;
            half_d  = 1'b0;
            shift_d = mem_q[addr_q[AW-1:0]];
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: if (fall) begin
          oe_d = 1'b1;
          if (!half_q) begin
            sio_out_d = shift_q[7:4];
            half_d    = 1'b1;
          end else begin
            // Low nibble is out: advance and prefetch so the next fall can use it.
            sio_out_d = shift_q[3:0];
            half_d    = 1'b0;
            addr_d    = addr_inc;
            shift_d   = rdmr_q ? 8'h40 : mem_q[addr_inc[AW-1:0]];
          end
        end
        ST_WDATA: if (rise) begin
          if (!half_q) begin
            shift_d = {sio_q, 4'h0};
            half_d  = 1'b1;
          end else begin
            mem_we  = 1'b1;
            half_d  = 1'b0;
            addr_d  = addr_inc;
          end
        end
        ST_SKIP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      sck_q      <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_q       <= 1'b1;
      sio_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      rdmr_q     <= 1'b0;
      half_q     <= 1'b0;
      addr_q     <= '0;
      shift_q    <= '0;
      sio_out_q  <= '0;
      oe_q       <= 1'b0;
    end else begin
      sck_q      <= i_mem_sck;
      sck_prev_q <= sck_q;
      cs_q       <= i_mem_cs;
      sio_q      <= i_mem_sio;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      rdmr_q     <= rdmr_d;
      half_q     <= half_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      sio_out_q  <= sio_out_d;
      oe_q       <= oe_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_mem_gck) begin
    if (mem_we) mem_q[addr_q[AW-1:0]] <= mem_wdata;
  end

  assign o_mem_sio    = sio_out_q;
  assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Randomized scoreboard bench for idli_sqi_mem_m against a byte-array model of the memory.
module tb_idli_sqi_mem_m;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       oe;

  int         total = 0;
  int         bad = 0;
  logic       rd_phase = 1'b0;
  logic [3:0] expq [$];
  logic [7:0] wq [$];
  logic [7:0] model [DEPTH];

  idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
    .i_mem_gck   (clk),
    .i_mem_rst_n (rst_n),
    .i_mem_sck   (sck),
    .i_mem_cs    (cs),
    .i_mem_sio   (sio_i),
    .o_mem_sio   (sio_o),
    .o_mem_sio_oe(oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: the initiator samples on every sck rise while selected.
  always @(posedge sck) begin
    if (!cs && rst_n) begin
      if (rd_phase) begin
        if (expq.size() == 0) chk("rd_unexpected", {3'b0, oe, sio_o}, 8'hFF);
        else chk("rd_nibble", {3'b0, oe, sio_o}, {4'b0001, expq.pop_front()});
      end else begin
        chk("oe_quiet", {7'b0, oe}, 8'h00);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n);
    sck = 1'b0; sio_i = n; tick(3);
    sck = 1'b1; tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic cs_low();
    sck = 1'b0; cs = 1'b0; tick(2);
  endtask

  task automatic cs_high();
    sck = 1'b0; tick(3);
    cs = 1'b1; tick(3);
    chk("cs_release", {3'b0, oe, sio_o}, 8'h00);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  // Writes the bytes queued in wq; extra adds one orphan nibble that must be dropped.
  task automatic do_write(input logic [23:0] a, input bit extra);
    cs_low();
    send_hdr(8'h02, a);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i]);
      model[(int'(a) + i) % DEPTH] = wq[i];
    end
    if (extra) send_nib(4'hF);
    cs_high();
    wq.delete();
  endtask

  // Reads nn nibbles; if rst_after is set, resets asynchronously instead of releasing cs.
  task automatic do_read(input logic [23:0] a, input int nn, input bit rst_after);
    logic [7:0] b;
    cs_low();
    send_hdr(8'h03, a);
    send_nib(4'($urandom()));
    send_nib(4'($urandom()));
    chk("oe_before_fall", {7'b0, oe}, 8'h00);
    rd_phase = 1'b1;
    for (int k = 0; k < nn; k++) begin
      b = model[(int'(a[15:0]) + k / 2) % DEPTH];
      expq.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
      sck = 1'b0; tick(3);
      sck = 1'b1; tick(3);
    end
    rd_phase = 1'b0;
    if (rst_after) begin
      chk("pre_rst_oe", {7'b0, oe}, 8'h01);
      #3 rst_n = 1'b0;
      #1 chk("rst_async", {3'b0, oe, sio_o}, 8'h00);
      cs = 1'b1; sck = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
    end else begin
      cs_high();
    end
  endtask

  task automatic do_skip(input logic [7:0] cmd, input int nn);
    cs_low();
    send_byte(cmd);
    for (int k = 0; k < nn; k++) send_nib(4'($urandom()));
    cs_high();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] a;
    int n;
    tick(3);
    chk("reset_state", {3'b0, oe, sio_o}, 8'h00);
    rst_n = 1'b1;
    tick(2);
    chk("idle_after_reset", {3'b0, oe, sio_o}, 8'h00);

    // Fill the whole array with random data so every later read is defined.
    a = 24'($urandom());
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom()));
    do_write(a, 1'b0);
    do_read(24'($urandom()), 6, 1'b0);

    // Basic write/read of two bytes.
    wq.push_back(8'hA5); wq.push_back(8'h3C);
    do_write(24'h000010, 1'b0);
    do_read(24'h000010, 4, 1'b0);

    // Wrap-around with upper address bits ignored.
    wq.push_back(8'h11); do_write(24'h0000FF, 1'b0);
    wq.push_back(8'h22); do_write(24'h000000, 1'b0);
    do_read(24'h0100FF, 4, 1'b0);

    // Partial trailing nibble is discarded.
    wq.push_back(8'h00); wq.push_back(8'h00); do_write(24'h000040, 1'b0);
    wq.push_back(8'h77); do_write(24'h000040, 1'b1);
    do_read(24'h000040, 4, 1'b0);

    // Unknown command: no output, no array change (checked by later reads).
    do_skip(8'h9F, 8);
    do_read(24'h000010, 4, 1'b0);

`ifdef IDLI_SQI_MEM_RDMR_EN
    cs_low();
    send_byte(8'h05);
    rd_phase = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expq.push_back((k % 2 == 0) ? 4'h4 : 4'h0);
      sck = 1'b0; tick(3);
      sck = 1'b1; tick(3);
    end
    rd_phase = 1'b0;
    cs_high();
`else
    do_skip(8'h05, 4);
`endif

    // Reset mid-read, then re-read previously written data.
    do_read(24'h000010, 3, 1'b1);
    do_read(24'h000010, 4, 1'b0);

    // Randomized mix of writes and reads stopping at arbitrary nibbles.
    for (int it = 0; it < 14; it++) begin
      a = 24'($urandom());
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom()));
        do_write(a, $urandom_range(0, 3) == 0);
      end else begin
        do_read(a, $urandom_range(1, 9), 1'b0);
      end
    end
    do_read(a, 5, 1'b0);

    chk("queue_drain", 8'(expq.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
